muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer with the HI/LO register pair for the pipelined MIPS EX stage. It sits beside the main ALU and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Multiplies and divides are sequenced over 33 cycles using a shared 64-bit shift/accumulate register.
- It raises Stall toward the hazard unit whenever the pipeline tries to issue a new op or read HI/LO while a multiply or divide is in flight.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported; HI and LO are each WIDTH bits.
- ITER, WIDTH, number of shift iterations.
- CNT_W, $clog2(ITER)+1, iteration counter width.

Ports:
- CLK  in  1  clock, rising edge.
- Reset_L  in  1  asynchronous active-low reset.
- Start  in  1  EX-stage op valid; sampled at a rising edge.
- Op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- OpA  in  WIDTH  rs value (multiplicand/dividend/MT source).
- OpB  in  WIDTH  rt value (multiplier/divisor).
- ReadHiLo  in  1  an MFHI or MFLO is in EX this cycle.
- Flush  in  1  synchronous abort of an in-flight op.
- Busy  out  1  multiply or divide in flight.
- Stall  out  1  pipeline hold request.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.
- DivZero  out  1  one-cycle pulse when a DIV/DIVU with OpB==0 is accepted.

Behaviour:
- Reset: asynchronous on Reset_L=0 and effective immediately, including mid-operation. State=IDLE, counter=0, accumulator=0, HI=LO=0, DivZero=0, Busy=0, Stall=0.
- States: IDLE, MUL, DIV, FIX. Busy = (state != IDLE).
- Stall = Busy & (Start | ReadHiLo), combinational.
  - A Start while Busy is ignored; the pipeline holds and re-presents it.
  - Stall stays high through the FIX cycle, because HI/LO update only at the end of FIX.
- Accept: Start=1 in IDLE at edge E0.
  - MTHI/MTLO: HI or LO <= OpA at E0; state stays IDLE; no Busy.
  - DIV/DIVU with OpB==0: HI <= OpA, LO <= all-ones, DivZero=1 for the cycle after E0; state stays IDLE.
  - MULT/DIV (signed): capture |OpA|, |OpB| and the result-sign flags.
  - MULTU/DIVU: capture OpA, OpB unchanged.
  - Counter <= ITER-1; state <= MUL or DIV.
  - No-op codes: ignored.
- MUL (iterations at E1..E32): standard shift-add over the 64-bit accumulator, one bit per edge; the counter decrements each edge. When counter==0, go to FIX.
- DIV (E1..E32): restoring division, one quotient bit per edge, 33-bit trial subtract; the remainder is kept in the upper half and the quotient in the lower half.
- FIX (edge E33): apply sign correction and write HI/LO, then go to IDLE.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Result mapping:
    - MULT/MULTU: HI = product[63:32], LO = product[31:0].
    - DIV/DIVU: LO = quotient, HI = remainder.
- Timing: Busy is high for exactly 33 cycles; the new HI/LO are visible after E33.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps; no trap).
- Flush=1 while Busy: state <= IDLE at the next edge; HI/LO keep their prior values.
- Flush and Start in the same IDLE cycle: Flush wins and nothing is accepted.
- Arithmetic is modulo 2^WIDTH per half; no exceptions are raised.

Decomposition:
- Package muldiv_pkg holds:
  - Op encodings (OP_MULT..OP_MTLO).
  - State encoding (S_IDLE, S_MUL, S_DIV, S_FIX).
  - ITER constant.
- One sub-module: muldiv_cneg, a combinational conditional two's-complement negate, parameterised by width. It is instantiated for operand absolute values (WIDTH) and result correction (2*WIDTH).

Test Plan:
1. MULT OpA=0xFFFFFFFE, OpB=3 -> Busy high for 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA after E33.
2. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
3. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
4. DIVU 5/0 -> no Busy; HI=5, LO=0xFFFFFFFF; DivZero pulses one cycle. Then MTHI 0x1234 -> HI=0x1234 next cycle.
5. ReadHiLo=1 throughout a MULT -> Stall=1 for all 33 Busy cycles, low in the cycle after E33. A second Start during Busy -> Stall=1 and the op is ignored; it is accepted once IDLE.
6. Reset_L low at iteration 10 -> Busy=0 and HI=LO=0 immediately. Flush at iteration 10 instead -> IDLE next edge, HI/LO unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and encodings for the multiply/divide sequencer.
//   MD_WIDTH  - operand width (only 32 is supported)
//   MD_ITER   - shift iterations per multiply/divide
//   op_e      - EX-stage op codes presented on Op (11x decode as no-op)
//   state_e   - sequencer states
package muldiv_pkg;
  localparam int MD_WIDTH = 32;
  localparam int MD_ITER  = MD_WIDTH;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_e;
endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: EX-stage <-> HI/LO sequencer bundle.
//   master (pipeline): drives Start, Op, OpA, OpB, ReadHiLo, Flush;
//                      sees Busy, Stall, HI, LO, DivZero.
//   slave  (muldiv_seq): the reverse.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic             ReadHiLo;
  logic             Flush;
  logic             Busy;
  logic             Stall;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             DivZero;

  modport master (
    output Start, Op, OpA, OpB, ReadHiLo, Flush,
    input  Busy, Stall, HI, LO, DivZero
  );

  modport slave (
    input  Start, Op, OpA, OpB, ReadHiLo, Flush,
    output Busy, Stall, HI, LO, DivZero
  );
endinterface

// File: rtl/muldiv_cneg.sv
// muldiv_cneg: combinational conditional two's-complement negate.
//   i_neg - 1: output -i_val, 0: pass through
//   i_val - W-bit input
//   o_val - W-bit result (modulo 2^W)
module muldiv_cneg #(
  parameter int W = 32
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);
  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer with the HI/LO pair,
// plus MTHI/MTLO. One result bit per cycle over a shared 2*WIDTH accumulator,
// followed by one sign-fix cycle that writes HI/LO.
//   CLK     - clock, rising edge
//   Reset_L - asynchronous active-low reset
//   bus     - muldiv_seq_if.slave (op issue, HI/LO read hazard, results)
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITER  = MD_ITER,
  parameter int CNT_W = $clog2(ITER) + 1
) (
  input  logic        CLK,
  input  logic        Reset_L,
  muldiv_seq_if.slave bus
);
  state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_is_div, r_neg_res, r_neg_rem, r_divzero;

  logic               w_busy, w_accept, w_signed, w_is_mul, w_is_div, w_b_zero;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [WIDTH:0]     w_mul_sum, w_rem_sh, w_diff;
  logic               w_fits;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot, w_rem;

  assign w_busy   = (r_state != S_IDLE);
  assign w_accept = bus.Start & ~bus.Flush & ~w_busy;
  assign w_signed = (bus.Op == OP_MULT) | (bus.Op == OP_DIV);
  assign w_is_mul = (bus.Op == OP_MULT) | (bus.Op == OP_MULTU);
  assign w_is_div = (bus.Op == OP_DIV)  | (bus.Op == OP_DIVU);
  assign w_b_zero = (bus.OpB == '0);

  // Signed ops iterate on magnitudes; sign is restored in FIX.
  muldiv_cneg #(.W(WIDTH)) u_abs_a (
    .i_neg(w_signed & bus.OpA[WIDTH-1]), .i_val(bus.OpA), .o_val(w_abs_a));
  muldiv_cneg #(.W(WIDTH)) u_abs_b (
    .i_neg(w_signed & bus.OpB[WIDTH-1]), .i_val(bus.OpB), .o_val(w_abs_b));

  // Multiply: multiplier sits in the low half and shifts out LSB-first;
  // the partial product grows into the upper half with its carry.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                     (r_acc[0] ? {1'b0, r_b} : '0);

  // Divide: remainder in the upper half, dividend shifting into it from the
  // low half while quotient bits enter at the bottom. A set MSB on the
  // shifted remainder means it already exceeds any 32-bit divisor.
  assign w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_b};
  assign w_fits    = w_rem_sh[WIDTH] | ~w_diff[WIDTH];
  assign w_rem_nxt = w_fits ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];

  muldiv_cneg #(.W(2*WIDTH)) u_fix_prod (
    .i_neg(r_neg_res), .i_val(r_acc), .o_val(w_prod));
  muldiv_cneg #(.W(WIDTH)) u_fix_quot (
    .i_neg(r_neg_res), .i_val(r_acc[WIDTH-1:0]), .o_val(w_quot));
  muldiv_cneg #(.W(WIDTH)) u_fix_rem (
    .i_neg(r_neg_rem), .i_val(r_acc[2*WIDTH-1:WIDTH]), .o_val(w_rem));

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul)                   w_state_nxt = S_MUL;
        else if (w_accept && w_is_div && !w_b_zero) w_state_nxt = S_DIV;
      end
      S_MUL, S_DIV: if (r_cnt == '0) w_state_nxt = S_FIX;
      S_FIX:        w_state_nxt = S_IDLE;
      default:      w_state_nxt = S_IDLE;
    endcase
    if (bus.Flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_b       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_divzero <= 1'b0;
    end else begin
      r_divzero <= 1'b0;
      unique case (r_state)
        S_IDLE: if (w_accept) begin
          case (bus.Op)
            OP_MTHI: r_hi <= bus.OpA;
            OP_MTLO: r_lo <= bus.OpA;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              if (w_is_div && w_b_zero) begin
                r_hi      <= bus.OpA;
                r_lo      <= '1;
                r_divzero <= 1'b1;
              end else begin
                r_acc     <= {{WIDTH{1'b0}}, w_abs_a};
                r_b       <= w_abs_b;
                r_cnt     <= CNT_W'(ITER - 1);
                r_is_div  <= w_is_div;
                r_neg_res <= w_signed & (bus.OpA[WIDTH-1] ^ bus.OpB[WIDTH-1]);
                r_neg_rem <= w_signed & bus.OpA[WIDTH-1];
              end
            end
            default: ;
          endcase
        end
        S_MUL: begin
          r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
          r_cnt <= r_cnt - 1'b1;
        end
        S_DIV: begin
          r_acc <= {w_rem_nxt, r_acc[WIDTH-2:0], w_fits};
          r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: if (!bus.Flush) begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy    = w_busy;
  assign bus.Stall   = w_busy & (bus.Start | bus.ReadHiLo);
  assign bus.HI      = r_hi;
  assign bus.LO      = r_lo;
  assign bus.DivZero = r_divzero;
endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic CLK = 1'b0;
  logic Reset_L;
  int   n_pass = 0;
  int   n_tot  = 0;

  muldiv_seq_if #(.WIDTH(32)) bus();

  muldiv_seq #(.WIDTH(32)) dut (
    .CLK    (CLK),
    .Reset_L(Reset_L),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  // Issue one op and wait until Busy drops (bounded); returns Busy cycles.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int cyc);
    @(negedge CLK);
    bus.Start = 1'b1; bus.Op = op; bus.OpA = a; bus.OpB = b;
    @(negedge CLK);
    bus.Start = 1'b0;
    cyc = 0;
    while (bus.Busy && cyc < 100) begin
      cyc++;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset;
    Reset_L = 1'b0;
    bus.Start = 1'b0; bus.Op = 3'b111; bus.OpA = '0; bus.OpB = '0;
    bus.ReadHiLo = 1'b0; bus.Flush = 1'b0;
    repeat (2) @(negedge CLK);
    n_tot++;
    if ({bus.Busy, bus.Stall, bus.DivZero} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {bus.Busy, bus.Stall, bus.DivZero});
    else n_pass++;
    n_tot++;
    if ({bus.HI, bus.LO} !== 64'h0)
      $display("FAIL reset_hilo: got %h want 0", {bus.HI, bus.LO});
    else n_pass++;
    Reset_L = 1'b1;
  endtask

  task automatic test_mult;
    int cyc;
    run_op(OP_MULT, 32'hFFFFFFFE, 32'd3, cyc);
    n_tot++;
    if (cyc !== 33) $display("FAIL mult_busy: got %0d want 33", cyc); else n_pass++;
    n_tot++;
    if ({bus.HI, bus.LO} !== 64'hFFFFFFFF_FFFFFFFA)
      $display("FAIL mult_neg: got %h want FFFFFFFFFFFFFFFA", {bus.HI, bus.LO});
    else n_pass++;
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
    n_tot++;
    if ({bus.HI, bus.LO} !== 64'hFFFFFFFE_00000001)
      $display("FAIL multu_max: got %h want FFFFFFFE00000001", {bus.HI, bus.LO});
    else n_pass++;
    run_op(OP_MULT, 32'h00012345, 32'hFFFF0000, cyc);  // 0x12345 * -65536
    n_tot++;
    if ({bus.HI, bus.LO} !== 64'hFFFFFFFE_DCBB0000)
      $display("FAIL mult_mix: got %h want FFFFFFFEDCBB0000", {bus.HI, bus.LO});
    else n_pass++;
  endtask

  task automatic test_div;
    int cyc;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, cyc);
    n_tot++;
    if (cyc !== 33) $display("FAIL div_busy: got %0d want 33", cyc); else n_pass++;
    n_tot++;
    if ({bus.HI, bus.LO} !== 64'hFFFFFFFF_FFFFFFFD)
      $display("FAIL div_neg7_2: got %h want FFFFFFFFFFFFFFFD", {bus.HI, bus.LO});
    else n_pass++;
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
    n_tot++;
    if ({bus.HI, bus.LO} !== 64'h00000000_80000000)
      $display("FAIL div_ovf: got %h want 0000000080000000", {bus.HI, bus.LO});
    else n_pass++;
    run_op(OP_DIVU, 32'd100, 32'd7, cyc);
    n_tot++;
    if ({bus.HI, bus.LO} !== 64'h00000002_0000000E)
      $display("FAIL divu_100_7: got %h want 000000020000000E", {bus.HI, bus.LO});
    else n_pass++;
    run_op(OP_DIVU, 32'hFFFFFFFF, 32'h80000000, cyc);
    n_tot++;
    if ({bus.HI, bus.LO} !== 64'h7FFFFFFF_00000001)
      $display("FAIL divu_big: got %h want 7FFFFFFF00000001", {bus.HI, bus.LO});
    else n_pass++;
  endtask

  task automatic test_divzero_mt;
    @(negedge CLK);
    bus.Start = 1'b1; bus.Op = OP_DIVU; bus.OpA = 32'd5; bus.OpB = 32'd0;
    @(negedge CLK);
    bus.Start = 1'b0;
    n_tot++;
    if ({bus.Busy, bus.DivZero} !== 2'b01)
      $display("FAIL dz_flags: got busy/dz %b want 01", {bus.Busy, bus.DivZero});
    else n_pass++;
    n_tot++;
    if ({bus.HI, bus.LO} !== 64'h00000005_FFFFFFFF)
      $display("FAIL dz_hilo: got %h want 00000005FFFFFFFF", {bus.HI, bus.LO});
    else n_pass++;
    bus.Start = 1'b1; bus.Op = OP_MTHI; bus.OpA = 32'h1234;
    @(negedge CLK);
    bus.Start = 1'b0;
    n_tot++;
    if (bus.DivZero !== 1'b0) $display("FAIL dz_pulse: got %b want 0", bus.DivZero); else n_pass++;
    n_tot++;
    if ({bus.HI, bus.LO} !== 64'h00001234_FFFFFFFF)
      $display("FAIL mthi: got %h want 00001234FFFFFFFF", {bus.HI, bus.LO});
    else n_pass++;
    bus.Start = 1'b1; bus.Op = OP_MTLO; bus.OpA = 32'h5678;
    @(negedge CLK);
    bus.Start = 1'b0;
    n_tot++;
    if ({bus.HI, bus.LO, bus.Busy} !== {64'h00001234_00005678, 1'b0})
      $display("FAIL mtlo: got %h/%b want 0000123400005678/0", {bus.HI, bus.LO}, bus.Busy);
    else n_pass++;
  endtask

  task automatic test_stall;
    int cyc, stl;
    @(negedge CLK);
    bus.Start = 1'b1; bus.Op = OP_MULT; bus.OpA = 32'd7; bus.OpB = 32'd9;
    bus.ReadHiLo = 1'b1;
    @(negedge CLK);
    bus.Start = 1'b0;
    cyc = 0; stl = 0;
    while (bus.Busy && cyc < 100) begin
      if (bus.Stall) stl++;
      cyc++;
      @(negedge CLK);
    end
    n_tot++;
    if (stl !== 33) $display("FAIL stall_cnt: got %0d want 33", stl); else n_pass++;
    n_tot++;
    if (bus.Stall !== 1'b0) $display("FAIL stall_after: got %b want 0", bus.Stall); else n_pass++;
    bus.ReadHiLo = 1'b0;
    // Back-to-back: a Start held during Busy waits until IDLE.
    @(negedge CLK);
    bus.Start = 1'b1; bus.Op = OP_MULTU; bus.OpA = 32'd2; bus.OpB = 32'd3;
    @(negedge CLK);
    bus.Start = 1'b0;
    repeat (4) @(negedge CLK);
    bus.Start = 1'b1; bus.Op = OP_MTHI; bus.OpA = 32'hDEAD;
    #1;
    n_tot++;
    if (bus.Stall !== 1'b1) $display("FAIL stall_start: got %b want 1", bus.Stall); else n_pass++;
    cyc = 0;
    while (bus.Busy && cyc < 100) begin
      cyc++;
      @(negedge CLK);
    end
    n_tot++;
    if ({bus.HI, bus.LO} !== 64'h00000000_00000006)
      $display("FAIL b2b_held: got %h want 0000000000000006", {bus.HI, bus.LO});
    else n_pass++;
    @(negedge CLK);
    bus.Start = 1'b0;
    n_tot++;
    if ({bus.HI, bus.LO} !== 64'h0000DEAD_00000006)
      $display("FAIL b2b_accept: got %h want 0000DEAD00000006", {bus.HI, bus.LO});
    else n_pass++;
  endtask

  task automatic test_reset_flush;
    int cyc;
    @(negedge CLK);
    bus.Start = 1'b1; bus.Op = OP_MULT; bus.OpA = 32'd5; bus.OpB = 32'd5;
    @(negedge CLK);
    bus.Start = 1'b0;
    repeat (10) @(negedge CLK);
    Reset_L = 1'b0;
    #1;
    n_tot++;
    if ({bus.Busy, bus.HI, bus.LO} !== 65'h0)
      $display("FAIL mid_reset: got busy %b hilo %h want 0/0", bus.Busy, {bus.HI, bus.LO});
    else n_pass++;
    @(negedge CLK);
    Reset_L = 1'b1;
    run_op(OP_MTHI, 32'hAAAA, 32'd0, cyc);
    run_op(OP_MTLO, 32'hBBBB, 32'd0, cyc);
    @(negedge CLK);
    bus.Start = 1'b1; bus.Op = OP_MULT; bus.OpA = 32'd5; bus.OpB = 32'd5;
    @(negedge CLK);
    bus.Start = 1'b0;
    repeat (10) @(negedge CLK);
    bus.Flush = 1'b1;
    @(negedge CLK);
    bus.Flush = 1'b0;
    n_tot++;
    if (bus.Busy !== 1'b0) $display("FAIL flush_idle: got busy %b want 0", bus.Busy); else n_pass++;
    repeat (30) @(negedge CLK);
    n_tot++;
    if ({bus.HI, bus.LO} !== 64'h0000AAAA_0000BBBB)
      $display("FAIL flush_keep: got %h want 0000AAAA0000BBBB", {bus.HI, bus.LO});
    else n_pass++;
    // Flush beats Start in IDLE.
    bus.Start = 1'b1; bus.Op = OP_MTHI; bus.OpA = 32'h77; bus.Flush = 1'b1;
    @(negedge CLK);
    bus.Start = 1'b0; bus.Flush = 1'b0;
    n_tot++;
    if (bus.HI !== 32'h0000AAAA) $display("FAIL flush_start: got %h want 0000AAAA", bus.HI); else n_pass++;
    run_op(OP_MULTU, 32'd5, 32'd5, cyc);
    n_tot++;
    if ({cyc[7:0], bus.HI, bus.LO} !== {8'd33, 64'h00000000_00000019})
      $display("FAIL post_flush: got %0d/%h want 33/0000000000000019", cyc, {bus.HI, bus.LO});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_divzero_mt();
    test_stall();
    test_reset_flush();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
